ife_block_feeder: RTL and testbench
===================================

IFE_BLOCK_FEEDER -- requirements
Module: ife_block_feeder

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 4, instruction words per block.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, output block buffer entries.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1, run request; sampled only in IDLE.
REQ-006 SHALL have port base_addr, input, 32, word-aligned start address, latched on accepted start.
REQ-007 SHALL have port num_blocks, input, 8, blocks to emit this run, latched on accepted start.
REQ-008 SHALL have port imem_req, output, 1, instruction fetch request.
REQ-009 SHALL have port imem_addr, output, 32, fetch byte address.
REQ-010 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-011 SHALL have port imem_ack, input, 1, fetch complete; imem_rdata valid this cycle.
REQ-012 SHALL have port block_id_out, output, 8, id of presented block.
REQ-013 SHALL have port block_data_out, output, BLOCK_WORDS x 32, packed block; word 0 = lowest address.
REQ-014 SHALL have port block_valid_out, output, 1, block presented.
REQ-015 SHALL have port block_ready_in, input, 1, consumer accepts block.
REQ-016 SHALL have port busy, output, 1, high whenever FSM not in IDLE.
REQ-017 SHALL have port done, output, 1, one-cycle run-complete pulse.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, PUSH, DONE.
REQ-019 IDLE: start=1 SHALL latch base_addr/num_blocks, clear word index, go FETCH (num_blocks!=0) or DONE (num_blocks==0); start outside IDLE SHALL be ignored.
REQ-020 FETCH: imem_req SHALL be 1 with imem_addr held stable until imem_ack; ack with imem_req=0 SHALL be ignored.
REQ-021 On ack, word SHALL be stored in slot index, address +4 (wraps mod 2^32), index +1; on slot BLOCK_WORDS-1 go PUSH.
REQ-022 Zero-wait memory (ack same cycle as req) SHALL sustain one word per cycle.
REQ-023 PUSH: if FIFO not full (pre-pop, start-of-cycle) SHALL write {block_id counter, data}, increment id, decrement remaining; go DONE if remaining reaches 0 else FETCH; if full, stall in PUSH.
REQ-024 Block id counter SHALL persist across runs and wrap 255->0; cleared only by rst.
REQ-025 block_valid_out SHALL equal FIFO non-empty; pop on block_valid_out && block_ready_in.
REQ-026 While block_valid_out && !block_ready_in, block_id_out/block_data_out SHALL stay stable.
REQ-027 Simultaneous push and pop on a non-full FIFO SHALL both take effect; order preserved.
REQ-028 DONE: done SHALL be 1 exactly in the cycle FSM is in DONE with FIFO empty, then go IDLE.
REQ-029 Latency: start in cycle 0, zero-wait memory -> imem_req cycles 1-4, PUSH cycle 5, block_valid_out cycle 6.

Reset
REQ-030 rst SHALL asynchronously force IDLE, flush FIFO, clear id counter, address, index, remaining.
REQ-031 During/after reset: imem_req=0, imem_addr=0, block_valid_out=0, block_id_out=0, block_data_out=0, busy=0, done=0.
REQ-032 rst mid-fetch SHALL drop imem_req immediately; a late ack after reset SHALL be ignored.

Structure
REQ-033 ife_pkg SHALL hold BLOCK_WORDS, block_data_t, block_id_t (8-bit), feeder state enum.
REQ-034 Output buffer SHALL be sub-module ife_block_fifo (synchronous FIFO, depth FIFO_DEPTH, width 8+32*BLOCK_WORDS).

Verification
REQ-035 base 0x1000, num_blocks=1, ack every cycle, ready=1 -> addrs 0x1000..0x100C, block id 0, valid in cycle 6, done once.
REQ-036 num_blocks=3, ready=0 -> FIFO fills (2), FSM stalls in PUSH; raising ready -> ids 0,1,2 in order, no loss or duplicate.
REQ-037 ack delayed 3 cycles per word -> imem_addr stable while waiting; data words match memory in order.
REQ-038 num_blocks=0 -> done pulse cycle 1 or 2 after start, imem_req never asserted, no block emitted.
REQ-039 Two runs of 200 blocks -> ids wrap 255->0 in second run; start during run ignored.
REQ-040 rst asserted mid-FETCH with FIFO holding 1 block -> outputs per REQ-031 same cycle; next start emits id 0.

Source files
------------

// File: rtl/ife_pkg.sv
// Shared types and constants for the instruction-fetch block feeder.
// The block width comes from BLOCK_WORDS; ids are 8 bits wide and wrap naturally.
package ife_pkg;

  localparam int BLOCK_WORDS = 4;

  typedef logic [BLOCK_WORDS*32-1:0] block_data_t;
  typedef logic [7:0]                block_id_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PUSH  = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_e;

  function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/ife_block_fifo.sv
// Synchronous FIFO holding finished blocks; data appears one cycle after push.
// Pushes while full and pops while empty are dropped; push and pop may share a cycle.
module ife_block_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_pop_dat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_wr      = i_push && !o_full;
  assign w_rd      = i_pop && !o_empty;
  assign o_pop_dat = r_mem[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ife_block_feeder.sv
// Fetches BLOCK_WORDS words per block from imem and queues {id, data} blocks; first block valid 6 cycles after start.
// A full output buffer stalls the FSM in PUSH; the consumer drains it with valid/ready.
module ife_block_feeder #(
  parameter int BLOCK_WORDS = ife_pkg::BLOCK_WORDS,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [31:0]               base_addr,
  input  logic [7:0]                num_blocks,
  output logic                      imem_req,
  output logic [31:0]               imem_addr,
  input  logic [31:0]               imem_rdata,
  input  logic                      imem_ack,
  output logic [7:0]                block_id_out,
  output logic [BLOCK_WORDS*32-1:0] block_data_out,
  output logic                      block_valid_out,
  input  logic                      block_ready_in,
  output logic                      busy,
  output logic                      done
);

  import ife_pkg::*;

  localparam int IW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int DW = BLOCK_WORDS * 32;
  localparam int EW = 8 + DW;

  feeder_state_e r_state;
  logic [31:0]   r_addr;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_remaining;
  block_id_t     r_block_id;
  logic [DW-1:0] r_data;

  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_push;
  logic          w_pop;
  logic [EW-1:0] w_fifo_dout;

  // Fullness is the start-of-cycle view, so a same-cycle pop never frees room for this push.
  assign w_push = (r_state == ST_PUSH) && !w_fifo_full;
  assign w_pop  = !w_fifo_empty && block_ready_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_idx       <= '0;
      r_remaining <= '0;
      r_block_id  <= '0;
      r_data      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_addr      <= base_addr;
            r_remaining <= num_blocks;
            r_idx       <= '0;
            r_state     <= (num_blocks == 8'd0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (imem_ack) begin
            r_data[r_idx*32 +: 32] <= imem_rdata;
            r_addr                 <= next_word_addr(r_addr);
            if (r_idx == IW'(BLOCK_WORDS - 1)) begin
              r_idx   <= '0;
              r_state <= ST_PUSH;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        ST_PUSH: begin
          if (!w_fifo_full) begin
            r_block_id  <= r_block_id + 8'd1;
            r_remaining <= r_remaining - 8'd1;
            r_state     <= (r_remaining == 8'd1) ? ST_DONE : ST_FETCH;
          end
        end
        ST_DONE: begin
          if (w_fifo_empty) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  ife_block_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat ({r_block_id, r_data}),
    .i_pop      (w_pop),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_pop_dat  (w_fifo_dout)
  );

  assign imem_req        = (r_state == ST_FETCH);
  assign imem_addr       = r_addr;
  assign busy            = (r_state != ST_IDLE);
  assign done            = (r_state == ST_DONE) && w_fifo_empty;
  assign block_valid_out = !w_fifo_empty;
  assign block_id_out    = w_fifo_dout[EW-1 -: 8];
  assign block_data_out  = w_fifo_dout[DW-1:0];

endmodule

// File: tb/tb_ife_block_feeder.sv
// Scoreboard bench: a run-level model predicts fetch addresses and blocks; responder and monitor processes check them.
module tb_ife_block_feeder;

  localparam int BW = 4;
  localparam int FD = 2;

  typedef struct packed {
    logic [7:0]      id;
    logic [BW*32-1:0] data;
  } blk_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      base_addr;
  logic [7:0]       num_blocks;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata = '0;
  logic             imem_ack = 1'b0;
  logic [7:0]       block_id_out;
  logic [BW*32-1:0] block_data_out;
  logic             block_valid_out;
  logic             block_ready_in = 1'b0;
  logic             busy;
  logic             done;

  ife_block_feeder #(.BLOCK_WORDS(BW), .FIFO_DEPTH(FD)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .base_addr       (base_addr),
    .num_blocks      (num_blocks),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_ack        (imem_ack),
    .block_id_out    (block_id_out),
    .block_data_out  (block_data_out),
    .block_valid_out (block_valid_out),
    .block_ready_in  (block_ready_in),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string detail);
    checks++;
    failures++;
    $display("FAIL %s %s", name, detail);
  endtask

  // Reference model: memory content is a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  blk_t        exp_blk[$];
  logic [31:0] exp_addr[$];
  int          model_id = 0;

  task automatic model_run(input logic [31:0] base, input int n);
    logic [31:0] a;
    blk_t e;
    a = base;
    for (int b = 0; b < n; b++) begin
      e.id = 8'(model_id);
      for (int w = 0; w < BW; w++) begin
        e.data[w*32 +: 32] = mem_word(a);
        exp_addr.push_back(a);
        a = a + 32'd4;
      end
      exp_blk.push_back(e);
      model_id = (model_id + 1) % 256;
    end
  endtask

  // Memory responder: decides ack/data at the negedge for the next rising edge.
  int          delay_mode = 0;
  int          cur_delay = 0;
  int          waited = 0;
  logic        waiting = 1'b0;
  logic [31:0] held_addr = '0;
  logic        late_ack = 1'b0;
  int          req_cnt = 0;
  int          first_req_cyc = -1;

  function automatic int pick_delay();
    case (delay_mode)
      0:       return 0;
      1:       return 3;
      default: return int'($urandom_range(0, 3));
    endcase
  endfunction

  always @(negedge clk) begin
    if (late_ack) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      waiting    = 1'b0;
      waited     = 0;
    end else if (imem_req && !rst) begin
      req_cnt++;
      if (first_req_cyc < 0) first_req_cyc = cyc;
      if (waiting) check("addr_stable", imem_addr, held_addr);
      if (waited >= cur_delay) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        if (exp_addr.size() == 0) fail_now("unexpected_fetch", $sformatf("actual=%0h required=none", imem_addr));
        else check("fetch_addr", imem_addr, exp_addr.pop_front());
        waited    = 0;
        waiting   = 1'b0;
        cur_delay = pick_delay();
      end else begin
        imem_ack  = 1'b0;
        waited++;
        waiting   = 1'b1;
        held_addr = imem_addr;
      end
    end else begin
      imem_ack = 1'b0;
      waiting  = 1'b0;
      waited   = 0;
    end
  end

  // Output monitor: ready is chosen here, so a transfer happens at the next rising edge.
  int   ready_mode = 0;
  logic stall_prev = 1'b0;
  blk_t held_blk;
  blk_t got_exp;
  int   blk_seen = 0;
  int   first_valid_cyc = -1;

  always @(negedge clk) begin
    if (stall_prev && !rst) begin
      check("hold_valid", block_valid_out, 1'b1);
      check("hold_block", {block_id_out, block_data_out}, held_blk);
    end
    case (ready_mode)
      0:       block_ready_in = 1'b1;
      1:       block_ready_in = 1'b0;
      default: block_ready_in = ($urandom_range(0, 2) != 0);
    endcase
    if (block_valid_out && !rst) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (block_ready_in) begin
        blk_seen++;
        stall_prev = 1'b0;
        if (exp_blk.size() == 0) begin
          fail_now("unexpected_block", $sformatf("actual id=%0d required=none", block_id_out));
        end else begin
          got_exp = exp_blk.pop_front();
          check("block_id", block_id_out, got_exp.id);
          check("block_data", block_data_out, got_exp.data);
        end
      end else begin
        stall_prev = 1'b1;
        held_blk   = {block_id_out, block_data_out};
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  int done_cnt = 0;
  int last_done_cyc = -1;
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  int start_cyc = 0;

  task automatic do_start(input logic [31:0] base, input int n);
    @(negedge clk);
    start      = 1'b1;
    base_addr  = base;
    num_blocks = 8'(n);
    start_cyc  = cyc;
    model_run(base, n);
    @(negedge clk);
    start      = 1'b0;
    base_addr  = $urandom;
    num_blocks = 8'($urandom);
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt == d0) begin
      fail_now({name, "_timeout"}, $sformatf("actual=no_done required=done_within_%0d", budget));
    end else begin
      repeat (3) @(negedge clk);
      check({name, "_done_once"}, done_cnt - d0, 1);
      check({name, "_idle"}, busy, 1'b0);
      check({name, "_blocks_left"}, exp_blk.size(), 0);
      check({name, "_fetches_left"}, exp_addr.size(), 0);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_imem_req"}, imem_req, 1'b0);
    check({name, "_imem_addr"}, imem_addr, 32'd0);
    check({name, "_valid"}, block_valid_out, 1'b0);
    check({name, "_id"}, block_id_out, 8'd0);
    check({name, "_data"}, block_data_out, '0);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_done"}, done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    fail_now("watchdog", "actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen0;
    int bound;
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    num_blocks = '0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single block, zero-wait memory: latency profile.
    delay_mode = 0; ready_mode = 0; cur_delay = 0;
    req_cnt = 0; first_req_cyc = -1; first_valid_cyc = -1;
    do_start(32'h0000_1000, 1);
    wait_done("single", 100);
    check("lat_first_req", first_req_cyc - start_cyc, 1);
    check("req_cycles", req_cnt, 4);
    check("lat_valid", first_valid_cyc - start_cyc, 6);
    check("lat_done", last_done_cyc - start_cyc, 7);

    // Consumer stalled: buffer fills and the FSM waits in PUSH.
    ready_mode = 1;
    seen0 = blk_seen;
    do_start(32'h0000_2000, 3);
    repeat (40) @(negedge clk);
    check("stall_busy", busy, 1'b1);
    check("stall_no_req", imem_req, 1'b0);
    check("stall_valid", block_valid_out, 1'b1);
    check("stall_none_out", blk_seen - seen0, 0);
    check("stall_all_fetched", exp_addr.size(), 0);
    ready_mode = 0;
    wait_done("stall", 100);
    check("stall_count", blk_seen - seen0, 3);

    // Slow memory: three wait cycles per word.
    delay_mode = 1; cur_delay = 3; req_cnt = 0;
    do_start(32'h0000_4000, 2);
    wait_done("slow", 200);
    check("slow_req_cycles", req_cnt, 2 * BW * 4);

    // Empty run.
    delay_mode = 0; cur_delay = 0; req_cnt = 0;
    seen0 = blk_seen;
    do_start(32'h0000_3000, 0);
    wait_done("empty", 20);
    check("empty_done_cyc", last_done_cyc - start_cyc, 1);
    check("empty_no_req", req_cnt, 0);
    check("empty_no_block", blk_seen - seen0, 0);

    // Random runs including an address wrap past 2^32.
    delay_mode = 2; ready_mode = 2;
    do_start(32'hFFFF_FFF8, 2);
    wait_done("wrap_addr", 300);
    for (int r = 0; r < 4; r++) begin
      do_start($urandom & 32'hFFFF_FFFC, int'($urandom_range(1, 6)));
      wait_done("random", 600);
    end

    // Two long runs: ids wrap; a start mid-run must be ignored.
    for (int r = 0; r < 2; r++) begin
      delay_mode = 0; ready_mode = 2;
      do_start(32'h0001_0000 + 32'(r) * 32'h0001_0000, 200);
      repeat (50) @(negedge clk);
      start = 1'b1; base_addr = 32'hDEAD_0000; num_blocks = 8'd5;
      @(negedge clk);
      start = 1'b0;
      wait_done("long", 6000);
    end

    // Reset mid-fetch with one block buffered.
    delay_mode = 1; cur_delay = 3; ready_mode = 1;
    do_start(32'h0000_5000, 3);
    bound = 0;
    while (!(block_valid_out && imem_req) && bound < 200) begin
      @(negedge clk);
      bound++;
    end
    if (!(block_valid_out && imem_req)) fail_now("rst_setup", "actual=not_reached required=valid_and_req");
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    exp_blk.delete();
    exp_addr.delete();
    model_id = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    late_ack = 1'b1;
    repeat (2) @(negedge clk);
    late_ack = 1'b0;
    check("late_ack_idle", busy, 1'b0);
    check("late_ack_no_req", imem_req, 1'b0);
    delay_mode = 0; cur_delay = 0; ready_mode = 0;
    seen0 = blk_seen;
    do_start(32'h0000_6000, 2);
    wait_done("after_rst", 100);
    check("after_rst_count", blk_seen - seen0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
